hiscore_save_ctrl: RTL and testbench

HISCORE_SAVE_CTRL -- requirements
Module: hiscore_save_ctrl

---
 rtl/hiscore_pkg.sv | 28 ++
 rtl/hiscore_region_map.sv | 35 +++
 rtl/hiscore_save_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_hiscore_save_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hiscore_pkg.sv
// Shared types for the hiscore save controller: FSM state encoding, the
// region descriptor used by the flat-offset decoder, and a range-test helper.
package hiscore_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    CHECK_SIZE,
    WRITE_SIZE,
    START_READ,
    START_WRITE,
    WAIT_ACK,
    DONE
  } state_t;

  typedef struct packed {
    logic [15:0] base;
    logic [7:0]  len;
  } region_t;

  // True when a flat byte offset falls inside [start, start + len).
  function automatic logic region_hit(input logic [7:0] offset,
                                      input logic [8:0] start,
                                      input logic [7:0] len);
    return ({1'b0, offset} >= start) && ({1'b0, offset} < (start + 9'(len)));
  endfunction

endpackage

// File: rtl/hiscore_region_map.sv
// Flat byte offset -> core-RAM address decoder. Regions are listed MSB-first
// in REGION_BASE / REGION_LEN, so region 0 sits in the top slice.
import hiscore_pkg::*;

module hiscore_region_map #(
  parameter int                        NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*16-1:0] REGION_BASE = {16'h0620, 16'h057E},
  parameter logic [NUM_REGIONS*8-1:0]  REGION_LEN  = {8'h50, 8'h03}
) (
  input  logic [7:0]  offset,
  output logic        selected,
  output logic [15:0] hs_address
);

  logic [8:0] start;
  region_t    region;

  // Walk the regions accumulating the prefix sum; the first hit wins.
  always_comb begin
    selected   = 1'b0;
    hs_address = '0;
    start      = '0;
    region     = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      region.base = REGION_BASE[(NUM_REGIONS-1-k)*16 +: 16];
      region.len  = REGION_LEN[(NUM_REGIONS-1-k)*8 +: 8];
      if (!selected && region_hit(offset, start, region.len)) begin
        selected   = 1'b1;
        hs_address = region.base + 16'(offset - start[7:0]);
      end
      start = start + 9'(region.len);
    end
  end

endmodule

// File: rtl/hiscore_save_ctrl.sv
// Hiscore save controller: bridges flat byte accesses onto the core's
// hiscore RAM regions and sequences the load/save handshake with the APF
// dataslot interface. Optional feature macro: HISCORE_AUTOSAVE_EN enables
// save_req-triggered writes from DONE (otherwise save_req is ignored).
import hiscore_pkg::*;

module hiscore_save_ctrl #(
  parameter int                        NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*16-1:0] REGION_BASE = {16'h0620, 16'h057E},
  parameter logic [NUM_REGIONS*8-1:0]  REGION_LEN  = {8'h50, 8'h03},
  parameter int                        SLOT_ID     = 2,
  parameter int                        DT_ADDR     = 5,
  parameter logic [31:0]               BRIDGE_BASE = 32'h1000_0000,
  parameter logic [31:0]               START_DELAY = 32'h2349_3400,
  parameter logic [23:0]               ACK_TIMEOUT = 24'hFF_FFFF
) (
  input  logic        clk_74a,
  input  logic        reset,
  input  logic        core_running,
  input  logic [7:0]  mem_addr,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wr_data,
  input  logic        mem_rd,
  output logic [7:0]  mem_rd_data,
  output logic        mem_rd_valid,
  output logic [15:0] hs_address,
  output logic        hs_write_enable,
  output logic [7:0]  hs_data_in,
  input  logic [7:0]  hs_data_out,
  output logic [9:0]  datatable_addr,
  output logic [31:0] datatable_data,
  output logic        datatable_wren,
  input  logic [31:0] datatable_q,
  output logic        target_dataslot_read,
  output logic        target_dataslot_write,
  input  logic        target_dataslot_ack,
  output logic [15:0] target_dataslot_id,
  output logic [31:0] target_dataslot_slotoffset,
  output logic [31:0] target_dataslot_bridgeaddr,
  output logic [31:0] target_dataslot_length,
  output logic        processor_halt,
  input  logic        save_req,
  output logic        busy,
  output logic        timeout_err
);

  // Sum of all region lengths; callers keep this at or below 255.
  function automatic logic [8:0] calc_total();
    logic [8:0] sum;
    sum = '0;
    for (int k = 0; k < NUM_REGIONS; k++)
      sum = sum + 9'(REGION_LEN[(NUM_REGIONS-1-k)*8 +: 8]);
    return sum;
  endfunction

  localparam logic [8:0] TOTAL_SUM = calc_total();
  localparam logic [7:0] TOTAL_LEN = TOTAL_SUM[7:0];

  logic        sel;
  logic        rd_vld_p1;
  logic        rd_sel_p1;
  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        timeout_set;

  hiscore_region_map #(
    .NUM_REGIONS(NUM_REGIONS),
    .REGION_BASE(REGION_BASE),
    .REGION_LEN (REGION_LEN)
  ) u_map (
    .offset    (mem_addr),
    .selected  (sel),
    .hs_address(hs_address)
  );

  // Writes go straight through in the request cycle; out-of-range ones drop.
  assign hs_data_in      = mem_wr_data;
  assign hs_write_enable = !reset && mem_wr && sel;

  assign datatable_addr             = 10'(DT_ADDR);
  assign datatable_data             = 32'(TOTAL_LEN);
  assign target_dataslot_id         = 16'(SLOT_ID);
  assign target_dataslot_slotoffset = '0;
  assign target_dataslot_bridgeaddr = BRIDGE_BASE;
  assign target_dataslot_length     = 32'(TOTAL_LEN);

  // Read pipeline: p1 waits for the RAM's registered output, p2 returns it.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      rd_vld_p1    <= 1'b0;
      rd_sel_p1    <= 1'b0;
      mem_rd_valid <= 1'b0;
      mem_rd_data  <= 8'h00;
    end else begin
      // stage p1: request captured, write has priority over read
      rd_vld_p1    <= mem_rd && !mem_wr;
      rd_sel_p1    <= sel;
      // stage p2: data returned, zero for offsets beyond the regions
      mem_rd_valid <= rd_vld_p1;
      mem_rd_data  <= (rd_vld_p1 && rd_sel_p1) ? hs_data_out : 8'h00;
    end
  end

`ifdef HISCORE_AUTOSAVE_EN
  logic save_q, save_pend, save_rise, save_take;
  assign save_rise = save_req && !save_q;

  // Latch save requests that arrive while a transfer is still in flight.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      save_q    <= 1'b0;
      save_pend <= 1'b0;
    end else begin
      save_q <= save_req;
      if (save_take)
        save_pend <= 1'b0;
      else if (save_rise && busy)
        save_pend <= 1'b1;
    end
  end
`else
  logic unused_save;
  assign unused_save = save_req;
`endif

  // State, shared delay/timeout counter and sticky timeout flag.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (timeout_set)
        timeout_err <= 1'b1;
    end
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    state_nxt             = state;
    cnt_nxt               = cnt;
    timeout_set           = 1'b0;
    processor_halt        = 1'b0;
    busy                  = 1'b1;
    datatable_wren        = 1'b0;
    target_dataslot_read  = 1'b0;
    target_dataslot_write = 1'b0;
`ifdef HISCORE_AUTOSAVE_EN
    save_take             = 1'b0;
`endif
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (core_running) begin
          state_nxt = DELAY;
          cnt_nxt   = START_DELAY;
        end
      end
      DELAY: begin
        if (cnt == '0) state_nxt = CHECK_SIZE;
        else           cnt_nxt   = cnt - 32'd1;
      end
      CHECK_SIZE: begin
        processor_halt = 1'b1;
        state_nxt      = (datatable_q == '0) ? WRITE_SIZE : START_READ;
      end
      WRITE_SIZE: begin
        processor_halt = 1'b1;
        datatable_wren = 1'b1;
        state_nxt      = DONE;
      end
      START_READ: begin
        processor_halt       = 1'b1;
        target_dataslot_read = 1'b1;
        cnt_nxt              = 32'(ACK_TIMEOUT) - 32'd1;
        state_nxt            = WAIT_ACK;
      end
      START_WRITE: begin
        processor_halt        = 1'b1;
        target_dataslot_write = 1'b1;
        cnt_nxt               = 32'(ACK_TIMEOUT) - 32'd1;
        state_nxt             = WAIT_ACK;
      end
      WAIT_ACK: begin
        processor_halt = 1'b1;
        if (target_dataslot_ack) begin
          state_nxt = DONE;
        end else if (cnt == '0) begin
          timeout_set = 1'b1;
          state_nxt   = DONE;
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      DONE: begin
        busy = 1'b0;
`ifdef HISCORE_AUTOSAVE_EN
        if (save_pend || save_rise) begin
          save_take = 1'b1;
          state_nxt = START_WRITE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
    // Core leaving run state aborts whatever is in progress.
    if (!core_running) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      timeout_set = 1'b0;
`ifdef HISCORE_AUTOSAVE_EN
      save_take   = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_hiscore_save_ctrl.sv
// Self-checking bench for hiscore_save_ctrl (START_DELAY=4, ACK_TIMEOUT=8).
module tb_hiscore_save_ctrl;

  logic        clk_74a = 1'b0;
  logic        reset, core_running;
  logic [7:0]  mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_wr, mem_rd, mem_rd_valid;
  logic [15:0] hs_address;
  logic        hs_write_enable;
  logic [7:0]  hs_data_in, hs_data_out;
  logic [9:0]  datatable_addr;
  logic [31:0] datatable_data, datatable_q;
  logic        datatable_wren;
  logic        target_dataslot_read, target_dataslot_write, target_dataslot_ack;
  logic [15:0] target_dataslot_id;
  logic [31:0] target_dataslot_slotoffset, target_dataslot_bridgeaddr, target_dataslot_length;
  logic        processor_halt, save_req, busy, timeout_err;

  always #5 clk_74a = ~clk_74a;

  hiscore_save_ctrl #(.START_DELAY(32'd4), .ACK_TIMEOUT(24'd8)) dut (
    .clk_74a(clk_74a), .reset(reset), .core_running(core_running),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wr_data(mem_wr_data), .mem_rd(mem_rd),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .hs_address(hs_address), .hs_write_enable(hs_write_enable),
    .hs_data_in(hs_data_in), .hs_data_out(hs_data_out),
    .datatable_addr(datatable_addr), .datatable_data(datatable_data),
    .datatable_wren(datatable_wren), .datatable_q(datatable_q),
    .target_dataslot_read(target_dataslot_read), .target_dataslot_write(target_dataslot_write),
    .target_dataslot_ack(target_dataslot_ack), .target_dataslot_id(target_dataslot_id),
    .target_dataslot_slotoffset(target_dataslot_slotoffset),
    .target_dataslot_bridgeaddr(target_dataslot_bridgeaddr),
    .target_dataslot_length(target_dataslot_length),
    .processor_halt(processor_halt), .save_req(save_req), .busy(busy), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk_74a) cyc <= cyc + 1;

  // Core hiscore RAM model: synchronous read, read-before-write.
  logic [7:0] hs_mem [0:65535];
  always @(posedge clk_74a) begin
    if (hs_write_enable === 1'b1) hs_mem[hs_address] <= hs_data_in;
    hs_data_out <= hs_mem[hs_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read scoreboard: expected byte and the cycle it must appear in.
  typedef struct {
    logic [7:0] data;
    int         when;
  } rd_exp_t;
  rd_exp_t sbq[$];

  always @(negedge clk_74a) begin
    rd_exp_t e;
    if (mem_rd_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("rd_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("rd_data", 32'(mem_rd_data), 32'(e.data));
        check("rd_cycle", 32'(cyc), 32'(e.when));
      end
    end else if (sbq.size() > 0 && sbq[0].when <= cyc) begin
      check("rd_missing_valid", 32'd0, 32'd1);
      e = sbq.pop_front();
    end
  end

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       chk_addr;
    logic [15:0] exp_addr;
    logic       exp_we;
    logic [7:0] exp_rd;
  } vec_t;

  task automatic step();
    @(posedge clk_74a);
    #1;
  endtask

  // One FSM run from IDLE; k counts cycles after core_running is driven,
  // so k=1 is the first cycle in DELAY and CHECK_SIZE lands on k=6.
  task automatic run_seq(input logic [31:0] dq, input int n, input int ack_k,
                         input int drop_k, input int end_k, input int wren_k,
                         input int read_k, input logic to_init, input int to_k,
                         input int save_k);
    step();
    datatable_q  = dq;
    core_running = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) step();
      target_dataslot_ack = (k == ack_k);
      save_req            = (k == save_k);
      if (k == drop_k) core_running = 1'b0;
      @(negedge clk_74a);
      check($sformatf("wren k=%0d", k), 32'(datatable_wren), 32'(k == wren_k));
      check($sformatf("rd_strobe k=%0d", k), 32'(target_dataslot_read), 32'(k == read_k));
      check($sformatf("wr_strobe k=%0d", k), 32'(target_dataslot_write), 32'd0);
      check($sformatf("halt k=%0d", k), 32'(processor_halt), 32'(k >= 6 && k <= end_k));
      check($sformatf("busy k=%0d", k), 32'(busy), 32'(k >= 1 && k <= end_k));
      check($sformatf("timeout k=%0d", k), 32'(timeout_err),
            32'((to_k >= 0 && k >= to_k) ? 1'b1 : to_init));
      if (k == read_k) check("length_at_read", target_dataslot_length, 32'd83);
    end
    step();
    core_running        = 1'b0;
    target_dataslot_ack = 1'b0;
    save_req            = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[13];
    int   c;

    for (int i = 0; i < 65536; i++) hs_mem[i] = 8'h00;
    hs_mem[16'h0580] = 8'h5C;
    hs_mem[16'h0000] = 8'h77;

    // Reset with every input trying to provoke activity.
    reset = 1'b1; core_running = 1'b1; mem_addr = 8'h00; mem_wr = 1'b1;
    mem_wr_data = 8'hEE; mem_rd = 1'b1; datatable_q = '0;
    target_dataslot_ack = 1'b0; save_req = 1'b1;
    repeat (3) @(posedge clk_74a);
    @(negedge clk_74a);
    check("rst_hs_we", 32'(hs_write_enable), 32'd0);
    check("rst_rd_valid", 32'(mem_rd_valid), 32'd0);
    check("rst_rd_data", 32'(mem_rd_data), 32'd0);
    check("rst_halt", 32'(processor_halt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wren", 32'(datatable_wren), 32'd0);
    check("rst_rd_strobe", 32'(target_dataslot_read), 32'd0);
    check("rst_wr_strobe", 32'(target_dataslot_write), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    step();
    reset = 1'b0; core_running = 1'b0; mem_wr = 1'b0; mem_rd = 1'b0; save_req = 1'b0;
    step();

    check("dt_addr", 32'(datatable_addr), 32'd5);
    check("dt_data", datatable_data, 32'd83);
    check("slot_id", 32'(target_dataslot_id), 32'd2);
    check("slot_off", target_dataslot_slotoffset, 32'd0);
    check("bridge", target_dataslot_bridgeaddr, 32'h1000_0000);
    check("length", target_dataslot_length, 32'd83);

    // Bridge accesses: {wr, rd, addr, wdata, chk_addr, exp_addr, exp_we, exp_rd}
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'hAA, 1'b1, 16'h0620, 1'b1, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h51, 8'h11, 1'b1, 16'h057F, 1'b1, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 8'h4F, 8'h22, 1'b1, 16'h066F, 1'b1, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 8'h50, 8'h33, 1'b1, 16'h057E, 1'b1, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 8'h53, 8'h44, 1'b0, 16'h0000, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 8'hFF, 8'h55, 1'b0, 16'h0000, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 8'h52, 8'h00, 1'b1, 16'h0580, 1'b0, 8'h5C};
    vecs[7]  = '{1'b0, 1'b1, 8'h53, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 16'h0620, 1'b0, 8'hAA};
    vecs[9]  = '{1'b1, 1'b1, 8'h10, 8'h99, 1'b1, 16'h0630, 1'b1, 8'h00};
    vecs[10] = '{1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 16'h0630, 1'b0, 8'h99};
    vecs[11] = '{1'b0, 1'b1, 8'h51, 8'h00, 1'b1, 16'h057F, 1'b0, 8'h11};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00};

    for (int i = 0; i < 13; i++) begin
      mem_wr      = vecs[i].wr;
      mem_rd      = vecs[i].rd;
      mem_addr    = vecs[i].addr;
      mem_wr_data = vecs[i].wdata;
      c = cyc;
      if (vecs[i].rd && !vecs[i].wr) sbq.push_back('{vecs[i].exp_rd, c + 2});
      @(negedge clk_74a);
      check($sformatf("hs_we v%0d", i), 32'(hs_write_enable), 32'(vecs[i].exp_we));
      if (vecs[i].chk_addr)
        check($sformatf("hs_addr v%0d", i), 32'(hs_address), 32'(vecs[i].exp_addr));
      if (vecs[i].exp_we)
        check($sformatf("hs_din v%0d", i), 32'(hs_data_in), 32'(vecs[i].wdata));
      step();
    end
    mem_wr = 1'b0; mem_rd = 1'b0;
    repeat (4) step();
    check("sb_drained", 32'(sbq.size()), 32'd0);

    // Size-zero path: wren on k=7, then DONE.
`ifdef HISCORE_AUTOSAVE_EN
    run_seq(32'd0, 12, -1, -1, 7, 7, -1, 1'b0, -1, -1);
`else
    run_seq(32'd0, 12, -1, -1, 7, 7, -1, 1'b0, -1, 9);
    run_seq(32'd0, 12, -1, -1, 7, 7, -1, 1'b0, -1, 3);
`endif
    // Load path acknowledged after three WAIT_ACK cycles.
    run_seq(32'd83, 14, 10, -1, 10, -1, 7, 1'b0, -1, -1);
    // Load path with no ack: 8 cycles in WAIT_ACK then sticky timeout.
    run_seq(32'd83, 19, -1, -1, 15, -1, 7, 1'b0, 16, -1);
    // Core drops while waiting: halt released on the next edge.
    run_seq(32'd83, 13, -1, 9, 9, -1, 7, 1'b1, -1, -1);

    // Reset in WAIT_ACK with a read in flight: everything clears at once.
    step();
    datatable_q = 32'd83; core_running = 1'b1; mem_addr = 8'h52;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) step();
      mem_rd = (k == 7);
      if (k == 8) reset = 1'b1;
      if (k == 10) begin reset = 1'b0; core_running = 1'b0; end
      @(negedge clk_74a);
      if (k == 8) check("pre_reset_halt", 32'(processor_halt), 32'd1);
      if (k == 9) begin
        check("midrst_halt", 32'(processor_halt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rd_strobe", 32'(target_dataslot_read), 32'd0);
        check("midrst_timeout", 32'(timeout_err), 32'd0);
        check("midrst_rd_valid", 32'(mem_rd_valid), 32'd0);
      end
    end
    step();
    step();

`ifdef HISCORE_AUTOSAVE_EN
    // save_req during DELAY is held and serviced once DONE is reached.
    step();
    datatable_q = 32'd0; core_running = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) step();
      save_req            = (k == 3);
      target_dataslot_ack = (k == 11);
      @(negedge clk_74a);
      check($sformatf("pend_wr k=%0d", k), 32'(target_dataslot_write), 32'(k == 9));
      check($sformatf("pend_halt k=%0d", k), 32'(processor_halt),
            32'((k >= 6 && k <= 7) || (k >= 9 && k <= 11)));
      check($sformatf("pend_busy k=%0d", k), 32'(busy),
            32'((k >= 1 && k <= 7) || (k >= 9 && k <= 11)));
    end
    // save_req edge while sitting in DONE.
    for (int j = 0; j < 7; j++) begin
      step();
      save_req            = (j == 1);
      target_dataslot_ack = (j == 3);
      @(negedge clk_74a);
      check($sformatf("save_wr j=%0d", j), 32'(target_dataslot_write), 32'(j == 2));
      check($sformatf("save_halt j=%0d", j), 32'(processor_halt), 32'(j >= 2 && j <= 3));
      check($sformatf("save_busy j=%0d", j), 32'(busy), 32'(j >= 2 && j <= 3));
    end
    step();
    save_req = 1'b0; target_dataslot_ack = 1'b0; core_running = 1'b0;
    step();
`endif

    check("sb_final", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
